// File: rtl/gps_carrier_wipeoff_if.sv
// Purpose: bundles the sample input, NCO controls, mixer output and integrated-result handshake of gps_carrier_wipeoff.
// Latency: none; signal container only.
// Backpressure: acc_valid/acc_ready carries the result handshake; the sample and mixer streams are valid-only.
//
// Signals:
//   dv_in, real_in, imag_in : sample strobe and signed 6-bit I/Q sample
//   freq, dump_len          : NCO phase increment, samples per integration period
//   mix_dv, mix_i, mix_q    : wiped-off sample stream (MIX_W signed)
//   acc_valid, acc_ready    : integrated result handshake
//   acc_i, acc_q, overrun   : integrated I/Q (ACC_W signed), sticky dropped-result flag
// Modports: master = sample source / result consumer, slave = wipe-off block.
interface gps_carrier_wipeoff_if #(
    parameter int ACC_W = 24,
    parameter int MIX_W = 13
);
    logic                    dv_in;
    logic signed [5:0]       real_in;
    logic signed [5:0]       imag_in;
    logic [31:0]             freq;
    logic [15:0]             dump_len;
    logic                    mix_dv;
    logic signed [MIX_W-1:0] mix_i;
    logic signed [MIX_W-1:0] mix_q;
    logic                    acc_valid;
    logic                    acc_ready;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic                    overrun;

    modport master (
        output dv_in, real_in, imag_in, freq, dump_len, acc_ready,
        input  mix_dv, mix_i, mix_q, acc_valid, acc_i, acc_q, overrun
    );

    modport slave (
        input  dv_in, real_in, imag_in, freq, dump_len, acc_ready,
        output mix_dv, mix_i, mix_q, acc_valid, acc_i, acc_q, overrun
    );
endinterface

// File: rtl/gps_carrier_wipeoff.sv
// Purpose: carrier wipe-off - mixes complex 6-bit samples with the conjugate NCO tone, then integrate-and-dump.
// Latency: mix_dv follows dv_in by 3 cycles; a dump appears on acc_valid 1 cycle after its last mixed sample.
// Backpressure: one-entry result register; a dump arriving while it is full and not drained is dropped and sets overrun.
//
// Ports: clk, resetn (synchronous, active-low), bus (gps_carrier_wipeoff_if.slave).
// Parameters: ACC_W accumulator/result width (14..32), MIX_W mixer width (fixed at 13).
// Build option: define CWO_SATURATE_EN for saturating accumulation (sticky per period);
//   without it the accumulators wrap modulo 2^ACC_W.
module gps_carrier_wipeoff #(
    parameter int ACC_W = 24,
    parameter int MIX_W = 13
) (
    input  logic                  clk,
    input  logic                  resetn,
    gps_carrier_wipeoff_if.slave  bus
);

    // Magnitude of 31*cos over the first quadrant, index 0..16 in steps of 2*pi/64.
    function automatic logic [4:0] quarter_mag(input logic [4:0] m);
        logic [4:0] r;
        case (m)
            5'd0:    r = 5'd31;
            5'd1:    r = 5'd31;
            5'd2:    r = 5'd30;
            5'd3:    r = 5'd30;
            5'd4:    r = 5'd29;
            5'd5:    r = 5'd27;
            5'd6:    r = 5'd26;
            5'd7:    r = 5'd24;
            5'd8:    r = 5'd22;
            5'd9:    r = 5'd20;
            5'd10:   r = 5'd17;
            5'd11:   r = 5'd15;
            5'd12:   r = 5'd12;
            5'd13:   r = 5'd9;
            5'd14:   r = 5'd6;
            5'd15:   r = 5'd3;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Full-circle cosine from quadrant symmetry: quadrants 1 and 3 mirror the index,
    // quadrants 1 and 2 negate the result.
    function automatic logic signed [5:0] cos_lut(input logic [5:0] k);
        logic [4:0] m;
        logic [4:0] mag;
        m   = {1'b0, k[3:0]};
        mag = quarter_mag(k[4] ? (5'd16 - m) : m);
        return (k[5] ^ k[4]) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    // ---------------- NCO ----------------
    logic [31:0] phase;
    logic [5:0]  lut_idx;

    assign lut_idx = phase[31:26];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase <= '0;
        end else if (bus.dv_in) begin
            phase <= phase + bus.freq;
        end
    end

    // ---------------- S1: sample + LUT ----------------
    logic              s1_vld;
    logic signed [5:0] s1_a, s1_b, s1_c, s1_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_c   <= '0;
            s1_d   <= '0;
        end else begin
            s1_vld <= bus.dv_in;
            if (bus.dv_in) begin
                s1_a <= bus.real_in;
                s1_b <= bus.imag_in;
                s1_c <= cos_lut(lut_idx);
                // sin(k) = cos(k - 16) on a 64-step circle
                s1_d <= cos_lut(lut_idx - 6'd16);
            end
        end
    end

    // ---------------- S2: products ----------------
    logic               s2_vld;
    logic signed [11:0] s2_ac, s2_bd, s2_bc, s2_ad;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s2_vld <= 1'b0;
            s2_ac  <= '0;
            s2_bd  <= '0;
            s2_bc  <= '0;
            s2_ad  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_ac <= s1_a * s1_c;
                s2_bd <= s1_b * s1_d;
                s2_bc <= s1_b * s1_c;
                s2_ad <= s1_a * s1_d;
            end
        end
    end

    // ---------------- S3: conjugate mix sums ----------------
    logic                    mix_dv_r;
    logic signed [MIX_W-1:0] mix_i_r, mix_q_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mix_dv_r <= 1'b0;
            mix_i_r  <= '0;
            mix_q_r  <= '0;
        end else begin
            mix_dv_r <= s2_vld;
            if (s2_vld) begin
                mix_i_r <= {s2_ac[11], s2_ac} + {s2_bd[11], s2_bd};
                mix_q_r <= {s2_bc[11], s2_bc} - {s2_ad[11], s2_ad};
            end
        end
    end

    assign bus.mix_dv = mix_dv_r;
    assign bus.mix_i  = mix_i_r;
    assign bus.mix_q  = mix_q_r;

    // ---------------- Integrate and dump ----------------
    logic [15:0]             cnt, len_q, len_in, cur_len;
    logic                    last, dump_fire;
    logic signed [ACC_W-1:0] acc_i_r, acc_q_r;
    logic signed [ACC_W-1:0] mix_ext_i, mix_ext_q;
    logic signed [ACC_W-1:0] sum_i, sum_q;

    assign mix_ext_i = {{(ACC_W-MIX_W){mix_i_r[MIX_W-1]}}, mix_i_r};
    assign mix_ext_q = {{(ACC_W-MIX_W){mix_q_r[MIX_W-1]}}, mix_q_r};

    // The first sample of a period uses the live dump_len; later samples use the copy latched then.
    assign len_in    = (bus.dump_len == 16'd0) ? 16'd1 : bus.dump_len;
    assign cur_len   = (cnt == 16'd0) ? len_in : len_q;
    assign last      = (cnt == cur_len - 16'd1);
    assign dump_fire = mix_dv_r & last;

`ifdef CWO_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_i, wide_q;
    logic           ovf_i, ovf_q;
    logic           sat_i, sat_q;

    // Once a rail is hit the accumulator stays pinned there until the period dumps.
    always_comb begin
        wide_i = {acc_i_r[ACC_W-1], acc_i_r} + {mix_ext_i[ACC_W-1], mix_ext_i};
        wide_q = {acc_q_r[ACC_W-1], acc_q_r} + {mix_ext_q[ACC_W-1], mix_ext_q};
        ovf_i  = wide_i[ACC_W] ^ wide_i[ACC_W-1];
        ovf_q  = wide_q[ACC_W] ^ wide_q[ACC_W-1];
        if (sat_i)      sum_i = acc_i_r;
        else if (ovf_i) sum_i = wide_i[ACC_W] ? ACC_MIN : ACC_MAX;
        else            sum_i = wide_i[ACC_W-1:0];
        if (sat_q)      sum_q = acc_q_r;
        else if (ovf_q) sum_q = wide_q[ACC_W] ? ACC_MIN : ACC_MAX;
        else            sum_q = wide_q[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sat_i <= 1'b0;
            sat_q <= 1'b0;
        end else if (mix_dv_r) begin
            sat_i <= last ? 1'b0 : (sat_i | ovf_i);
            sat_q <= last ? 1'b0 : (sat_q | ovf_q);
        end
    end
`else
    always_comb begin
        sum_i = acc_i_r + mix_ext_i;
        sum_q = acc_q_r + mix_ext_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            len_q   <= '0;
            acc_i_r <= '0;
            acc_q_r <= '0;
        end else if (mix_dv_r) begin
            if (cnt == 16'd0) begin
                len_q <= len_in;
            end
            if (last) begin
                cnt     <= '0;
                acc_i_r <= '0;
                acc_q_r <= '0;
            end else begin
                cnt     <= cnt + 16'd1;
                acc_i_r <= sum_i;
                acc_q_r <= sum_q;
            end
        end
    end

    // ---------------- Result register ----------------
    logic                    out_vld;
    logic signed [ACC_W-1:0] out_i, out_q;
    logic                    overrun_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_vld   <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            overrun_r <= 1'b0;
        end else if (dump_fire) begin
            if (!out_vld || bus.acc_ready) begin
                out_vld <= 1'b1;
                out_i   <= sum_i;
                out_q   <= sum_q;
            end else begin
                // Held result is never overwritten; the new dump is lost.
                overrun_r <= 1'b1;
            end
        end else if (out_vld && bus.acc_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.acc_valid = out_vld;
    assign bus.acc_i     = out_i;
    assign bus.acc_q     = out_q;
    assign bus.overrun   = overrun_r;

endmodule
